// File: rtl/jk_ff_checker.sv
// Cycle-accurate JK flip-flop reference checker: tracks a jk_ff stage from its sampled
// inputs and outputs, flags q/qb mismatches, and counts toggles and errors.
module jk_ff_checker #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_j,
  input  logic             i_k,
  input  logic             i_ff_set_n,
  input  logic             i_ff_rst_n,
  input  logic             i_q,
  input  logic             i_qb,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [1:0]       o_err_code,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_toggle_cnt,
  output logic [CYC_W-1:0] o_first_err_cyc
);

  typedef enum logic {S_UNSYNC, S_TRACK} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_exp;
  logic             r_q_prev;
  logic [CYC_W-1:0] r_cyc;

  logic       w_exp_q;
  logic       w_exp_nxt;
  logic [1:0] w_bits;
  logic       w_err;
  logic       w_toggle;

  // Async controls override the stored model; reset wins when both are low.
  always_comb begin
    w_exp_q = r_exp;
    if (!i_ff_rst_n)      w_exp_q = 1'b0;
    else if (!i_ff_set_n) w_exp_q = 1'b1;
  end

  // Next model is built from the sampled q, so a single fault is reported once.
  always_comb begin
    w_exp_nxt = i_q;
    if (!i_ff_rst_n)      w_exp_nxt = 1'b0;
    else if (!i_ff_set_n) w_exp_nxt = 1'b1;
    else begin
      case ({i_j, i_k})
        2'b00:   w_exp_nxt = i_q;
        2'b01:   w_exp_nxt = 1'b0;
        2'b10:   w_exp_nxt = 1'b1;
        default: w_exp_nxt = ~i_q;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_UNSYNC && i_en) w_state_nxt = S_TRACK;
  end

  assign w_bits[0] = (r_state == S_TRACK) && (i_q != w_exp_q);
  assign w_bits[1] = (i_qb == i_q);
  assign w_err     = i_en && !i_clr && (|w_bits);
  assign w_toggle  = i_en && (i_q != r_q_prev);
  assign o_locked  = (r_state == S_TRACK);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_UNSYNC;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp           <= 1'b0;
      r_q_prev        <= 1'b0;
      r_cyc           <= '0;
      o_err_pulse     <= 1'b0;
      o_err_code      <= 2'b00;
      o_err_sticky    <= 1'b0;
      o_err_cnt       <= '0;
      o_toggle_cnt    <= '0;
      o_first_err_cyc <= '0;
    end else begin
      o_err_pulse <= 1'b0;
      if (i_en) begin
        r_exp    <= w_exp_nxt;
        r_q_prev <= i_q;
      end
      if (i_clr) begin
        r_cyc           <= '0;
        o_err_code      <= 2'b00;
        o_err_sticky    <= 1'b0;
        o_err_cnt       <= '0;
        o_toggle_cnt    <= '0;
        o_first_err_cyc <= '0;
      end else if (i_en) begin
        r_cyc <= r_cyc + 1'b1;
        if (w_toggle && !(&o_toggle_cnt)) o_toggle_cnt <= o_toggle_cnt + 1'b1;
        if (w_err) begin
          o_err_pulse  <= 1'b1;
          o_err_code   <= w_bits;
          o_err_sticky <= 1'b1;
          if (!(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
          if (!o_err_sticky) o_first_err_cyc <= r_cyc;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed scoreboard bench for jk_ff_checker: each driven cycle queues its hand-computed
// expected outputs; a negedge monitor pops and compares them against the registered outputs.
module tb_jk_ff_checker;

  localparam int CNT_W = 4;
  localparam int CYC_W = 32;

  logic clk = 1'b0;
  logic rst, en, clr, j, k, set_n, rst_n, q, qb;
  logic             locked, err_pulse, err_sticky;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_cnt, toggle_cnt;
  logic [CYC_W-1:0] first_err_cyc;

  always #5 clk = ~clk;

  jk_ff_checker #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_j(j), .i_k(k),
    .i_ff_set_n(set_n), .i_ff_rst_n(rst_n), .i_q(q), .i_qb(qb),
    .o_locked(locked), .o_err_pulse(err_pulse), .o_err_code(err_code),
    .o_err_sticky(err_sticky), .o_err_cnt(err_cnt), .o_toggle_cnt(toggle_cnt),
    .o_first_err_cyc(first_err_cyc)
  );

  typedef struct {
    int lk, ep, ec, es, ecnt, tcnt, fc;
    int step;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_step = 0;

  task automatic chk(input string name, input int step, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, expv);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("locked",        e.step, int'(locked),        e.lk);
      chk("err_pulse",     e.step, int'(err_pulse),     e.ep);
      chk("err_code",      e.step, int'(err_code),      e.ec);
      chk("err_sticky",    e.step, int'(err_sticky),    e.es);
      chk("err_cnt",       e.step, int'(err_cnt),       e.ecnt);
      chk("toggle_cnt",    e.step, int'(toggle_cnt),    e.tcnt);
      chk("first_err_cyc", e.step, int'(first_err_cyc), e.fc);
    end
  end

  // One clock: drive inputs, then queue what the outputs must read after this edge.
  task automatic t(input logic r, input logic e_n, input logic c, input logic jj, input logic kk,
                   input logic sn, input logic rn, input logic qq, input logic qqb,
                   input int lk, input int ep, input int ec, input int es,
                   input int ecnt, input int tcnt, input int fc);
    exp_t x;
    @(negedge clk);
    rst = r; en = e_n; clr = c; j = jj; k = kk; set_n = sn; rst_n = rn; q = qq; qb = qqb;
    @(posedge clk);
    x.lk = lk; x.ep = ep; x.ec = ec; x.es = es; x.ecnt = ecnt; x.tcnt = tcnt; x.fc = fc;
    x.step = n_step;
    n_step++;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0;
    set_n = 1'b1; rst_n = 1'b1; q = 1'b0; qb = 1'b1;

    // reset
    t(1,0,0, 0,0,1,1, 0,1,  0,0,0,0,0,0,0);
    t(1,0,0, 0,0,1,1, 0,1,  0,0,0,0,0,0,0);
    // lock, then first toggle
    t(0,1,0, 1,0,1,1, 0,1,  1,0,0,0,0,0,0);
    t(0,1,0, 1,1,1,1, 1,0,  1,0,0,0,0,1,0);
    // jk=11 toggling with a correct flop
    t(0,1,0, 1,1,1,1, 0,1,  1,0,0,0,0,2,0);
    t(0,1,0, 1,1,1,1, 1,0,  1,0,0,0,0,3,0);
    t(0,1,0, 1,1,1,1, 0,1,  1,0,0,0,0,4,0);
    t(0,1,0, 1,1,1,1, 1,0,  1,0,0,0,0,5,0);
    // hold, then forced q flip at cyc=10
    t(0,1,0, 0,0,1,1, 0,1,  1,0,0,0,0,6,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,0,0,0,0,6,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,0,0,0,0,6,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,0,0,0,0,6,0);
    t(0,1,0, 0,0,1,1, 1,0,  1,1,1,1,1,7,10);
    t(0,1,0, 0,0,1,1, 1,0,  1,0,1,1,1,7,10);
    // both async controls low: reset wins
    t(0,1,0, 0,0,0,0, 1,0,  1,1,1,1,2,7,10);
    t(0,1,0, 0,0,0,0, 0,0,  1,1,2,1,3,8,10);
    t(0,1,0, 0,0,0,1, 1,0,  1,0,2,1,3,9,10);
    // en=0 freezes everything even with bad outputs
    t(0,0,0, 0,0,1,1, 0,0,  1,0,2,1,3,9,10);
    t(0,1,0, 0,0,1,1, 1,0,  1,0,2,1,3,9,10);
    // 20 qb errors while toggling: both counters saturate, pulse every cycle
    for (int n = 1; n <= 20; n++) begin
      logic qv;
      int   ec_e, tc_e;
      qv   = (n % 2 == 1);
      ec_e = (3 + n > 15) ? 15 : 3 + n;
      tc_e = (8 + n > 15) ? 15 : 8 + n;
      t(0,1,0, 1,1,1,1, qv,qv,  1,1,2,1,ec_e,tc_e,10);
    end
    // clear, and clear racing an error
    t(0,1,1, 0,0,1,1, 1,0,  1,0,0,0,0,0,0);
    t(0,1,1, 0,0,1,1, 1,1,  1,0,0,0,0,0,0);
    t(0,1,0, 0,0,1,1, 1,0,  1,0,0,0,0,0,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,1,1,1,1,1,1);
    // reset mid-run, en=0 must neither lock nor advance cyc
    t(1,1,0, 0,0,1,1, 0,1,  0,0,0,0,0,0,0);
    for (int n = 0; n < 5; n++) t(0,0,0, 0,0,1,1, 1,0,  0,0,0,0,0,0,0);
    t(0,1,0, 0,0,1,1, 1,0,  1,0,0,0,0,1,0);
    t(0,1,0, 0,0,1,1, 1,0,  1,0,0,0,0,1,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,1,1,1,1,2,2);
    // qb check is live on the locking cycle
    t(1,0,0, 0,0,1,1, 0,1,  0,0,0,0,0,0,0);
    t(0,1,0, 0,0,1,1, 0,0,  1,1,2,1,1,0,0);
    t(0,1,0, 0,0,1,1, 0,1,  1,0,2,1,1,0,0);

    @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
